updown_counter: RTL and testbench



---
 rtl/updown_counter.sv | 79 +++++++
 tb/tb_updown_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Parametrised up/down counter with saturate-or-wrap arithmetic and sticky overflow/underflow flags.
// value_next is combinational (zero latency), value registers it one cycle later; no backpressure, every step is accepted.
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int INCR_W   = 2,
  parameter int DECR_W   = 2,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  input  logic [WIDTH-1:0]  initial_value,
  input  logic              incr_valid,
  input  logic [INCR_W-1:0] incr,
  input  logic              decr_valid,
  input  logic [DECR_W-1:0] decr,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  value_next,
  output logic              overflow,
  output logic              underflow,
  output logic              is_zero,
  output logic              is_max
);

  localparam int RW = WIDTH + 2;
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0]  base;
  logic [INCR_W-1:0] add;
  logic [DECR_W-1:0] sub;
  logic [RW-1:0]     raw;
  logic              ovf_evt;
  logic              unf_evt;
  logic              step;

  // raw is two's complement in WIDTH+2 bits: bit RW-1 is the sign, bit WIDTH
  // set on a non-negative result means the sum exceeded the counter range.
  always_comb begin
    base    = reinit     ? initial_value : value;
    add     = incr_valid ? incr : '0;
    sub     = decr_valid ? decr : '0;
    raw     = {2'b00, base}
            + {{(RW-INCR_W){1'b0}}, add}
            - {{(RW-DECR_W){1'b0}}, sub};
    unf_evt = raw[RW-1];
    ovf_evt = ~raw[RW-1] & raw[WIDTH];
    step    = reinit | incr_valid | decr_valid;

    value_next = raw[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (ovf_evt)      value_next = MAX_VAL;
      else if (unf_evt) value_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= initial_value;
    end else if (step) begin
      value <= value_next;
    end
  end

  // A new event beats both reinit and clear_flags in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~reinit & ~clear_flags);
      underflow <= unf_evt | (underflow & ~reinit & ~clear_flags);
    end
  end

  assign is_zero = (value == '0);
  assign is_max  = (value == MAX_VAL);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter at WIDTH=4: a saturating and a wrapping instance share stimulus.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       reinit;
  logic [3:0] initial_value;
  logic       incr_valid;
  logic [1:0] incr;
  logic       decr_valid;
  logic [1:0] decr;
  logic       clear_flags;

  logic [3:0] value_s, value_next_s, value_w, value_next_w;
  logic       overflow_s, underflow_s, is_zero_s, is_max_s;
  logic       overflow_w, underflow_w, is_zero_w, is_max_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .INCR_W(2), .DECR_W(2), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
    .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
    .clear_flags(clear_flags), .value(value_s), .value_next(value_next_s),
    .overflow(overflow_s), .underflow(underflow_s), .is_zero(is_zero_s), .is_max(is_max_s)
  );

  updown_counter #(.WIDTH(4), .INCR_W(2), .DECR_W(2), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
    .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
    .clear_flags(clear_flags), .value(value_w), .value_next(value_next_w),
    .overflow(overflow_w), .underflow(underflow_w), .is_zero(is_zero_w), .is_max(is_max_w)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    reinit = 1'b1; initial_value = v; incr_valid = 1'b0; decr_valid = 1'b0;
    tick();
    reinit = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; reinit = 1'b0; initial_value = 4'd5; incr_valid = 1'b0; incr = 2'd0;
    decr_valid = 1'b0; decr = 2'd0; clear_flags = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++; if (value_s !== 4'd5) begin n_fail++; $display("FAIL reset_value: got %0d expected 5", value_s); end
    n_checks++; if ({overflow_s, underflow_s} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {overflow_s, underflow_s}); end
    n_checks++; if ({is_zero_s, is_max_s} !== 2'b00) begin n_fail++; $display("FAIL reset_zero_max: got %b expected 00", {is_zero_s, is_max_s}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (value_s !== 4'd5) begin n_fail++; $display("FAIL idle_value[%0d]: got %0d expected 5", i, value_s); end
      n_checks++; if (value_next_s !== 4'd5) begin n_fail++; $display("FAIL idle_value_next[%0d]: got %0d expected 5", i, value_next_s); end
    end
  endtask

  task automatic test_saturate_high;
    load(4'd14);
    incr_valid = 1'b1; incr = 2'd3;
    #1;
    n_checks++; if (value_next_s !== 4'd15) begin n_fail++; $display("FAIL sat_value_next: got %0d expected 15", value_next_s); end
    tick();
    n_checks++; if (value_s !== 4'd15) begin n_fail++; $display("FAIL sat_value: got %0d expected 15", value_s); end
    n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %b expected 1", overflow_s); end
    n_checks++; if (is_max_s !== 1'b1) begin n_fail++; $display("FAIL sat_is_max: got %b expected 1", is_max_s); end
    n_checks++; if (value_w !== 4'd1) begin n_fail++; $display("FAIL wrap_14p3: got %0d expected 1", value_w); end
    incr = 2'd1;
    tick();
    incr_valid = 1'b0;
    n_checks++; if (value_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold_value: got %0d expected 15", value_s); end
    n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL sat_hold_overflow: got %b expected 1", overflow_s); end
  endtask

  task automatic test_wrap_net;
    load(4'd15);
    incr_valid = 1'b1; incr = 2'd2; decr_valid = 1'b1; decr = 2'd1;
    #1;
    n_checks++; if (value_next_w !== 4'd0) begin n_fail++; $display("FAIL wrap_value_next: got %0d expected 0", value_next_w); end
    tick();
    n_checks++; if (value_w !== 4'd0) begin n_fail++; $display("FAIL wrap_value: got %0d expected 0", value_w); end
    n_checks++; if (overflow_w !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %b expected 1", overflow_w); end
    n_checks++; if (is_zero_w !== 1'b1) begin n_fail++; $display("FAIL wrap_is_zero: got %b expected 1", is_zero_w); end
    load(4'd1);
    decr_valid = 1'b1; decr = 2'd3;
    tick();
    decr_valid = 1'b0;
    n_checks++; if (value_w !== 4'd14) begin n_fail++; $display("FAIL wrap_under_value: got %0d expected 14", value_w); end
    n_checks++; if (underflow_w !== 1'b1) begin n_fail++; $display("FAIL wrap_underflow: got %b expected 1", underflow_w); end
    n_checks++; if (value_s !== 4'd0) begin n_fail++; $display("FAIL sat_low_value: got %0d expected 0", value_s); end
    n_checks++; if (underflow_s !== 1'b1) begin n_fail++; $display("FAIL sat_underflow: got %b expected 1", underflow_s); end
  endtask

  task automatic test_simultaneous;
    load(4'd15);
    incr_valid = 1'b1; incr = 2'd3; decr_valid = 1'b1; decr = 2'd3;
    tick();
    incr_valid = 1'b0; decr_valid = 1'b0;
    n_checks++; if (value_s !== 4'd15 || value_w !== 4'd15) begin n_fail++; $display("FAIL simul_value: got sat=%0d wrap=%0d expected 15", value_s, value_w); end
    n_checks++; if ({overflow_s, underflow_s, overflow_w, underflow_w} !== 4'b0000) begin n_fail++; $display("FAIL simul_flags: got %b expected 0000", {overflow_s, underflow_s, overflow_w, underflow_w}); end
  endtask

  task automatic test_reinit_step;
    load(4'd9);
    reinit = 1'b1; initial_value = 4'd2; decr_valid = 1'b1; decr = 2'd3;
    #1;
    n_checks++; if (value_next_s !== 4'd0) begin n_fail++; $display("FAIL reinit_value_next: got %0d expected 0", value_next_s); end
    tick();
    n_checks++; if (value_s !== 4'd0) begin n_fail++; $display("FAIL reinit_sat_value: got %0d expected 0", value_s); end
    n_checks++; if (underflow_s !== 1'b1) begin n_fail++; $display("FAIL reinit_underflow: got %b expected 1", underflow_s); end
    n_checks++; if (value_w !== 4'd15 || underflow_w !== 1'b1) begin n_fail++; $display("FAIL reinit_wrap: got value=%0d unf=%b expected 15/1", value_w, underflow_w); end
    decr = 2'd1;
    tick();
    reinit = 1'b0; decr_valid = 1'b0;
    n_checks++; if (value_s !== 4'd1) begin n_fail++; $display("FAIL reinit2_value: got %0d expected 1", value_s); end
    n_checks++; if ({overflow_s, underflow_s} !== 2'b00) begin n_fail++; $display("FAIL reinit2_flags: got %b expected 00", {overflow_s, underflow_s}); end
  endtask

  task automatic test_flag_clear;
    load(4'd14);
    incr_valid = 1'b1; incr = 2'd3;
    tick();
    n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL clr_setup_overflow: got %b expected 1", overflow_s); end
    incr_valid = 1'b0; clear_flags = 1'b1;
    tick();
    n_checks++; if (overflow_s !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow_s); end
    n_checks++; if (value_s !== 4'd15) begin n_fail++; $display("FAIL clr_value: got %0d expected 15", value_s); end
    incr_valid = 1'b1; incr = 2'd1;
    tick();
    clear_flags = 1'b0; incr_valid = 1'b0;
    n_checks++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins: got %b expected 1", overflow_s); end
  endtask

  task automatic test_reset_priority;
    rst = 1'b1; initial_value = 4'd3; incr_valid = 1'b1; incr = 2'd2;
    tick();
    n_checks++; if (value_s !== 4'd3 || value_w !== 4'd3) begin n_fail++; $display("FAIL rst_mid_value: got sat=%0d wrap=%0d expected 3", value_s, value_w); end
    n_checks++; if ({overflow_s, underflow_s} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 00", {overflow_s, underflow_s}); end
    initial_value = 4'd7;
    tick();
    n_checks++; if (value_s !== 4'd7) begin n_fail++; $display("FAIL rst_held_value: got %0d expected 7", value_s); end
    rst = 1'b0;
    tick();
    incr_valid = 1'b0;
    n_checks++; if (value_s !== 4'd9) begin n_fail++; $display("FAIL rst_release_incr: got %0d expected 9", value_s); end
  endtask

  initial begin
    test_reset();
    test_saturate_high();
    test_wrap_net();
    test_simultaneous();
    test_reinit_step();
    test_flag_clear();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
